chan_err_inj: RTL
=================

Name: chan_err_inj

Overview:
- Parametrised channel-impairment block between the convolutional encoder output and the Viterbi decoder input in the tx/rx link.
- Generalises fixed single-bit error injection to:
  - any symbol width,
  - LFSR-driven programmable error rate,
  - four injection modes, including multi-symbol bursts,
  - saturating statistics counters for bit-error accounting.
- Registered, single pipeline stage; the decoder sees sym_o/valid_o.

Parameters:
W, 2, symbol width in bits (power of two, 2..8)
LFSR_W, 16, PRNG width (16 only supported; Galois taps x^16+x^14+x^13+x^11+1)
RATE_W, 8, width of error-rate threshold
BURST_W, 4, width of burst length
CT_W, 16, width of each statistics counter
SEED, 16'hACE1, LFSR reset/reload value (nonzero)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-low reset
valid_i  input  1  symbol strobe from encoder
sym_i  input  W  encoder symbol
mode_i  input  2  0=off, 1=single-bit, 2=all-bits, 3=burst
rate_i  input  RATE_W  injection threshold; all-ones = inject every trigger
burst_len_i  input  BURST_W  symbols per burst (0 treated as 1)
clr_i  input  1  synchronous clear of counters, LFSR reload, burst abort
valid_o  output  1  registered valid_i
sym_o  output  W  registered, possibly corrupted symbol
err_mask_o  output  W  bits flipped in sym_o (sym_o = sym_d ^ err_mask_o)
word_ct_o  output  CT_W  valid symbols passed
inj_sym_ct_o  output  CT_W  symbols with nonzero mask
inj_bit_ct_o  output  CT_W  total flipped bits

Behaviour:
- Reset (rst low, async): all outputs 0, LFSR=SEED, FSM=IDLE, burst counter 0.
- Latency is exactly 1 cycle.
  - valid_o(t+1) = valid_i(t).
  - sym_o/err_mask_o update only when valid_i; otherwise they hold.
- LFSR advances one step per valid_i cycle. It does not advance when valid_i is low.
- Trigger definition: trig = valid_i & (rate_i == all-ones | lfsr[RATE_W-1:0] < rate_i), using current (pre-advance) LFSR state.
- Mode 0: mask=0 always.
- Mode 1: on trig, mask = one-hot at index lfsr[LFSR_W-1 -: log2(W)].
- Mode 2: on trig, mask = all-ones.
- Mode 3, FSM IDLE/BURST:
  - IDLE with trig: mask all-ones, remaining = max(burst_len_i,1)-1; go to BURST if remaining>0.
  - BURST with valid_i: mask all-ones, remaining decrements; go to IDLE when it reaches 0. Triggers are ignored in BURST.
  - burst_len_i is sampled only at burst start.
  - If mode_i != 3 while in BURST: the FSM returns to IDLE on that cycle, and the current symbol uses the new mode's rule.
- Counters, on valid_i:
  - word_ct +1.
  - inj_sym_ct +1 if mask != 0.
  - inj_bit_ct + popcount(mask).
  - All three saturate at 2^CT_W-1 and never wrap.
- clr_i has priority over valid_i:
  - counters <= 0, LFSR <= SEED, FSM <= IDLE.
  - A coincident symbol still passes with mask=0 and is not counted.
- Mode/rate changes take effect on the same cycle; no internal shadowing except burst_len_i.
- rst mid-burst: immediate return to reset state; no residual flips after rst release.

Optional Feature:
CHAN_ERR_INJ_FORCE_EN
- Defined:
  - Adds port force_i (input, 1).
  - trig = valid_i & (force_i | rate condition).
  - Force is ignored in mode 0 and ignored while in BURST.
- Undefined: no force_i port; trig depends on rate only.

Test Plan:
- Reset then mode 1, rate 0, 100 valid symbols of 2'b01 -> sym_o=2'b01 one cycle later each; word_ct=100, inj_sym_ct=0, inj_bit_ct=0.
- Mode 2, rate 8'hFF, 10 symbols 2'b01 -> sym_o=2'b10 and err_mask_o=2'b11 each; inj_sym_ct=10, inj_bit_ct=20.
- Mode 3, rate 8'hFF, burst_len 4, 2 symbols, then mode 0 for 3 symbols:
  - first 2 outputs fully inverted, last 3 clean;
  - FSM returns to IDLE; inj_bit_ct=4.
- CT_W=4 override, mode 2, rate 8'hFF, 20 symbols -> all counters saturate at 15 and hold.
- Mode 1, rate 8'h40, 1000 symbols, then clr_i coincident with a valid symbol, then repeat the run:
  - the coincident symbol is clean and uncounted;
  - the second run's err_mask_o sequence is identical to the first (LFSR reload);
  - the bench model matches every mask.
- Mode 3, burst_len 8, assert rst low after 3 burst symbols, release, mode 0 -> all outputs 0 during reset; no flips after release.

Source files
------------

// File: rtl/chan_err_inj.sv
// Channel impairment between convolutional encoder and Viterbi decoder: LFSR-gated
// bit flips (single / all / burst) with saturating error statistics. Optional CHAN_ERR_INJ_FORCE_EN adds force_i.
module chan_err_inj #(
   parameter int          W       = 2,
   parameter int          LFSR_W  = 16,
   parameter int          RATE_W  = 8,
   parameter int          BURST_W = 4,
   parameter int          CT_W    = 16,
   parameter logic [15:0] SEED    = 16'hACE1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid_i,
   input  logic [W-1:0]      sym_i,
   input  logic [1:0]        mode_i,
   input  logic [RATE_W-1:0] rate_i,
   input  logic [BURST_W-1:0] burst_len_i,
   input  logic              clr_i,
`ifdef CHAN_ERR_INJ_FORCE_EN
   input  logic              force_i,
`endif
   output logic              valid_o,
   output logic [W-1:0]      sym_o,
   output logic [W-1:0]      err_mask_o,
   output logic [CT_W-1:0]   word_ct_o,
   output logic [CT_W-1:0]   inj_sym_ct_o,
   output logic [CT_W-1:0]   inj_bit_ct_o
);

   localparam int IDX_W = $clog2(W);
   localparam int PC_W  = $clog2(W + 1);
   localparam logic [LFSR_W-1:0] TAPS = 16'hB400;

   typedef enum logic {S_IDLE, S_BURST} state_t;

   state_t              state_q;
   logic [BURST_W-1:0]  rem_q;
   logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
   logic                valid_q;
   logic [W-1:0]        sym_q, mask_q, mask_d, one_hot;
   logic [CT_W-1:0]     word_ct_q, inj_sym_ct_q, inj_bit_ct_q;
   logic                rate_hit, trig, in_burst;
   logic [BURST_W-1:0]  burst_rem_d;
   logic [PC_W-1:0]     pop_cnt;

   function automatic logic [CT_W-1:0] sat_add(input logic [CT_W-1:0] a, input logic [CT_W-1:0] b);
      logic [CT_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[CT_W] ? {CT_W{1'b1}} : s[CT_W-1:0];
   endfunction

   always_comb begin
      rate_hit = (rate_i == {RATE_W{1'b1}}) || (lfsr_q[RATE_W-1:0] < rate_i);
`ifdef CHAN_ERR_INJ_FORCE_EN
      trig = valid_i & ~clr_i & (rate_hit | force_i);
`else
      trig = valid_i & ~clr_i & rate_hit;
`endif
      // a burst only survives while mode 3 stays selected
      in_burst    = (state_q == S_BURST) && (mode_i == 2'd3);
      one_hot     = W'(1) << lfsr_q[LFSR_W-1 -: IDX_W];
      burst_rem_d = (burst_len_i == '0) ? '0 : burst_len_i - 1'b1;
      lfsr_d      = lfsr_q[0] ? ((lfsr_q >> 1) ^ TAPS) : (lfsr_q >> 1);
      mask_d      = '0;
      case (mode_i)
         2'd1:    if (trig) mask_d = one_hot;
         2'd2:    if (trig) mask_d = '1;
         2'd3:    if (in_burst ? (valid_i & ~clr_i) : trig) mask_d = '1;
         default: mask_d = '0;
      endcase
      pop_cnt = '0;
      for (int k = 0; k < W; k++) pop_cnt = pop_cnt + PC_W'(mask_d[k]);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         rem_q        <= '0;
         lfsr_q       <= SEED;
         valid_q      <= 1'b0;
         sym_q        <= '0;
         mask_q       <= '0;
         word_ct_q    <= '0;
         inj_sym_ct_q <= '0;
         inj_bit_ct_q <= '0;
      end else begin
         valid_q <= valid_i;
         if (clr_i) begin
            state_q      <= S_IDLE;
            rem_q        <= '0;
            lfsr_q       <= SEED;
            word_ct_q    <= '0;
            inj_sym_ct_q <= '0;
            inj_bit_ct_q <= '0;
            if (valid_i) begin
               sym_q  <= sym_i;
               mask_q <= '0;
            end
         end else begin
            if (valid_i) begin
               sym_q        <= sym_i ^ mask_d;
               mask_q       <= mask_d;
               lfsr_q       <= lfsr_d;
               word_ct_q    <= sat_add(word_ct_q, CT_W'(1));
               inj_sym_ct_q <= sat_add(inj_sym_ct_q, CT_W'(|mask_d));
               inj_bit_ct_q <= sat_add(inj_bit_ct_q, CT_W'(pop_cnt));
            end
            if (mode_i != 2'd3) begin
               state_q <= S_IDLE;
            end else if (valid_i) begin
               if (state_q == S_BURST) begin
                  rem_q <= rem_q - 1'b1;
                  if (rem_q == BURST_W'(1)) state_q <= S_IDLE;
               end else if (trig) begin
                  rem_q <= burst_rem_d;
                  if (burst_rem_d != '0) state_q <= S_BURST;
               end
            end
         end
      end
   end

   assign valid_o      = valid_q;
   assign sym_o        = sym_q;
   assign err_mask_o   = mask_q;
   assign word_ct_o    = word_ct_q;
   assign inj_sym_ct_o = inj_sym_ct_q;
   assign inj_bit_ct_o = inj_bit_ct_q;

endmodule
